// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache/memory channel arbiter.
//   ch_state_e       : per-channel FSM state encoding
//   DEF_*            : default block parameters
//   idx_bits()       : index width for a count (at least 1 bit)
//   DEF_*_IDX_BITS   : index widths derived from the default consumer/channel counts
package cache_mem_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ_WAITING,
      WRITE_WAITING,
      READ_RELAYING,
      WRITE_RELAYING
   } ch_state_e;

   localparam int DEF_ADDR_BITS     = 8;
   localparam int DEF_DATA_BITS     = 8;
   localparam int DEF_NUM_CONSUMERS = 8;
   localparam int DEF_NUM_CHANNELS  = 2;

   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_CONS_IDX_BITS = idx_bits(DEF_NUM_CONSUMERS);
   localparam int DEF_CHAN_IDX_BITS = idx_bits(DEF_NUM_CHANNELS);

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between cache ports, the arbiter and the memory channels.
//   consumer_* : per cache port fill (read) and writeback (write) handshakes
//   mem_*      : per memory channel read/write handshakes
// Modports:
//   slave  : the arbiter (answers consumers, drives memory requests)
//   master : the environment (drives consumer requests and memory responses)
interface cache_mem_arbiter_if #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 8,
   parameter int NUM_CHANNELS  = 2
);
   logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
   logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
   logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
   logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
   logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
   logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

   logic [NUM_CHANNELS-1:0]                 mem_read_valid;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
   logic [NUM_CHANNELS-1:0]                 mem_read_ready;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
   logic [NUM_CHANNELS-1:0]                 mem_write_valid;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
   logic [NUM_CHANNELS-1:0]                 mem_write_ready;

   modport slave (
      input  consumer_read_valid, consumer_read_address,
      input  consumer_write_valid, consumer_write_address, consumer_write_data,
      output consumer_read_ready, consumer_read_data, consumer_write_ready,
      output mem_read_valid, mem_read_address,
      output mem_write_valid, mem_write_address, mem_write_data,
      input  mem_read_ready, mem_read_data, mem_write_ready
   );

   modport master (
      output consumer_read_valid, consumer_read_address,
      output consumer_write_valid, consumer_write_address, consumer_write_data,
      input  consumer_read_ready, consumer_read_data, consumer_write_ready,
      input  mem_read_valid, mem_read_address,
      input  mem_write_valid, mem_write_address, mem_write_data,
      output mem_read_ready, mem_read_data, mem_write_ready
   );
endinterface

// File: rtl/cache_mem_arbiter_rr_picker.sv
// Masked priority picker: first set bit of i_req scanning upward from
// i_start, wrapping at N.
//   i_req   : candidate mask
//   i_start : index with highest priority
//   o_grant : one-hot winner
//   o_valid : a winner exists
//   o_idx   : binary index of the winner
module rr_picker #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_start,
   output logic [N-1:0]     o_grant,
   output logic             o_valid,
   output logic [IDX_W-1:0] o_idx
);
   logic [IDX_W:0] w_pos;

   always_comb begin
      o_grant = '0;
      o_valid = 1'b0;
      o_idx   = '0;
      w_pos   = '0;
      for (int k = 0; k < N; k++) begin
         w_pos = {1'b0, i_start} + (IDX_W+1)'(k);
         if (w_pos >= (IDX_W+1)'(N)) begin
            w_pos = w_pos - (IDX_W+1)'(N);
         end
         if (!o_valid && i_req[w_pos[IDX_W-1:0]]) begin
            o_valid                   = 1'b1;
            o_grant[w_pos[IDX_W-1:0]] = 1'b1;
            o_idx                     = w_pos[IDX_W-1:0];
         end
      end
   end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS cache ports.
// Each channel owns at most one consumer at a time and relays one read or
// write transaction; writebacks win over fills from the same consumer.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   bus     : cache_mem_arbiter_if.slave (consumer and memory handshakes)
// Build option:
//   CACHE_ARB_ROUND_ROBIN_EN defined   -> round-robin start pointer
//   CACHE_ARB_ROUND_ROBIN_EN undefined -> fixed priority, consumer 0 highest
//
// state          | meaning
// IDLE           | free, may be granted a consumer this cycle
// READ_WAITING   | mem read request out, waiting for mem_read_ready
// WRITE_WAITING  | mem write request out, waiting for mem_write_ready
// READ_RELAYING  | consumer_read_ready high until the owner drops read valid
// WRITE_RELAYING | consumer_write_ready high until the owner drops write valid
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int ADDR_BITS     = DEF_ADDR_BITS,
   parameter int DATA_BITS     = DEF_DATA_BITS,
   parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
   parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS
) (
   input  logic               i_clk,
   input  logic               i_reset,
   cache_mem_arbiter_if.slave bus
);
   localparam int IDX_W = idx_bits(NUM_CONSUMERS);

   ch_state_e                r_state      [NUM_CHANNELS];
   ch_state_e                w_state_nxt  [NUM_CHANNELS];
   logic [IDX_W-1:0]         r_owner      [NUM_CHANNELS];
   logic [IDX_W-1:0]         w_owner_nxt  [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]     r_addr       [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]     w_addr_nxt   [NUM_CHANNELS];
   logic [DATA_BITS-1:0]     r_wdata      [NUM_CHANNELS];
   logic [DATA_BITS-1:0]     w_wdata_nxt  [NUM_CHANNELS];
   logic [DATA_BITS-1:0]     r_rdata      [NUM_CHANNELS];
   logic [DATA_BITS-1:0]     w_rdata_nxt  [NUM_CHANNELS];
   logic                     w_pick_vld   [NUM_CHANNELS];
   logic [IDX_W-1:0]         w_pick_idx   [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] w_owned;
   logic [NUM_CONSUMERS-1:0] w_elig;
   logic [IDX_W-1:0]         w_start;

   // An owned consumer stays ineligible through WAITING and RELAYING, so a
   // held read valid behind a writeback is only picked after the write ends.
   always_comb begin
      w_owned = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (r_state[c] != IDLE) begin
            w_owned[r_owner[c]] = 1'b1;
         end
      end
   end

   assign w_elig = (bus.consumer_read_valid | bus.consumer_write_valid) & ~w_owned;

   // Pickers are chained in ascending channel order; each sees only the
   // consumers not already taken by a lower channel this cycle.
   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      logic [NUM_CONSUMERS-1:0] w_avail;
      logic [NUM_CONSUMERS-1:0] w_req;
      logic [NUM_CONSUMERS-1:0] w_gnt;
      logic [NUM_CONSUMERS-1:0] w_left;
      if (c == 0) begin : g_head
         assign w_avail = w_elig;
      end else begin : g_tail
         assign w_avail = g_ch[c-1].w_left;
      end
      assign w_req  = (r_state[c] == IDLE) ? w_avail : '0;
      assign w_left = w_avail & ~w_gnt;
      rr_picker #(.N(NUM_CONSUMERS), .IDX_W(IDX_W)) u_pick (
         .i_req   (w_req),
         .i_start (w_start),
         .o_grant (w_gnt),
         .o_valid (w_pick_vld[c]),
         .o_idx   (w_pick_idx[c])
      );
   end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_ptr_nxt;

   // Highest channel granted this cycle wins, i.e. the last grant made.
   always_comb begin
      w_ptr_nxt = r_ptr;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (w_pick_vld[c]) begin
            w_ptr_nxt = (w_pick_idx[c] == IDX_W'(NUM_CONSUMERS-1)) ? '0
                        : w_pick_idx[c] + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) r_ptr <= '0;
      else         r_ptr <= w_ptr_nxt;
   end

   assign w_start = r_ptr;
`else
   assign w_start = '0;
`endif

   always_comb begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         w_state_nxt[c] = r_state[c];
         w_owner_nxt[c] = r_owner[c];
         w_addr_nxt[c]  = r_addr[c];
         w_wdata_nxt[c] = r_wdata[c];
         w_rdata_nxt[c] = r_rdata[c];
         case (r_state[c])
            IDLE: begin
               if (w_pick_vld[c]) begin
                  w_owner_nxt[c] = w_pick_idx[c];
                  if (bus.consumer_write_valid[w_pick_idx[c]]) begin
                     w_state_nxt[c] = WRITE_WAITING;
                     w_addr_nxt[c]  = bus.consumer_write_address[w_pick_idx[c]];
                     w_wdata_nxt[c] = bus.consumer_write_data[w_pick_idx[c]];
                  end else begin
                     w_state_nxt[c] = READ_WAITING;
                     w_addr_nxt[c]  = bus.consumer_read_address[w_pick_idx[c]];
                  end
               end
            end
            // A requester that gave up meanwhile gets no ready; the memory
            // transaction is still finished.
            READ_WAITING: begin
               if (bus.mem_read_ready[c]) begin
                  w_rdata_nxt[c] = bus.mem_read_data[c];
                  w_state_nxt[c] = bus.consumer_read_valid[r_owner[c]] ? READ_RELAYING : IDLE;
               end
            end
            WRITE_WAITING: begin
               if (bus.mem_write_ready[c]) begin
                  w_state_nxt[c] = bus.consumer_write_valid[r_owner[c]] ? WRITE_RELAYING : IDLE;
               end
            end
            READ_RELAYING: begin
               if (!bus.consumer_read_valid[r_owner[c]]) w_state_nxt[c] = IDLE;
            end
            WRITE_RELAYING: begin
               if (!bus.consumer_write_valid[r_owner[c]]) w_state_nxt[c] = IDLE;
            end
            default: w_state_nxt[c] = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (i_reset) begin
            r_state[c] <= IDLE;
            r_owner[c] <= '0;
            r_addr[c]  <= '0;
            r_wdata[c] <= '0;
            r_rdata[c] <= '0;
         end else begin
            r_state[c] <= w_state_nxt[c];
            r_owner[c] <= w_owner_nxt[c];
            r_addr[c]  <= w_addr_nxt[c];
            r_wdata[c] <= w_wdata_nxt[c];
            r_rdata[c] <= w_rdata_nxt[c];
         end
      end
   end

   always_comb begin
      bus.consumer_read_ready  = '0;
      bus.consumer_read_data   = '0;
      bus.consumer_write_ready = '0;
      bus.mem_read_valid       = '0;
      bus.mem_read_address     = '0;
      bus.mem_write_valid      = '0;
      bus.mem_write_address    = '0;
      bus.mem_write_data       = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         bus.mem_read_valid[c]    = (r_state[c] == READ_WAITING);
         bus.mem_read_address[c]  = r_addr[c];
         bus.mem_write_valid[c]   = (r_state[c] == WRITE_WAITING);
         bus.mem_write_address[c] = r_addr[c];
         bus.mem_write_data[c]    = r_wdata[c];
         if (r_state[c] == READ_RELAYING) begin
            bus.consumer_read_ready[r_owner[c]] = 1'b1;
            bus.consumer_read_data[r_owner[c]]  = r_rdata[c];
         end
         if (r_state[c] == WRITE_RELAYING) begin
            bus.consumer_write_ready[r_owner[c]] = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter (default parameters). Expectations
// that depend on the arbitration policy follow CACHE_ARB_ROUND_ROBIN_EN.
module tb_cache_mem_arbiter;
   localparam int AB  = 8;
   localparam int DB  = 8;
   localparam int NC  = 8;
   localparam int NCH = 2;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cnt [NC];
   int   grants;
   int   gi;

   always #5 clk = ~clk;

   cache_mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)) bus ();

   cache_mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.consumer_read_valid    = '0;
      bus.consumer_read_address  = '0;
      bus.consumer_write_valid   = '0;
      bus.consumer_write_address = '0;
      bus.consumer_write_data    = '0;
      bus.mem_read_ready         = '0;
      bus.mem_read_data          = '0;
      bus.mem_write_ready        = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mrv"},  64'(bus.mem_read_valid),       64'h0);
      chk({tag, "_mwv"},  64'(bus.mem_write_valid),      64'h0);
      chk({tag, "_mra"},  64'(bus.mem_read_address),     64'h0);
      chk({tag, "_mwa"},  64'(bus.mem_write_address),    64'h0);
      chk({tag, "_mwd"},  64'(bus.mem_write_data),       64'h0);
      chk({tag, "_crr"},  64'(bus.consumer_read_ready),  64'h0);
      chk({tag, "_cwr"},  64'(bus.consumer_write_ready), 64'h0);
      chk({tag, "_crd"},  64'(bus.consumer_read_data),   64'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] e;
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      chk_all_zero("rst");
      reset = 1'b0;

      // single read: consumer 3, addr 0x40, data 0xA5 at t+4
      bus.consumer_read_valid[3]   = 1'b1;
      bus.consumer_read_address[3] = 8'h40;
      step();
      chk("rd_mrv_t1",  64'(bus.mem_read_valid),      64'h1);
      chk("rd_mra_t1",  64'(bus.mem_read_address[0]), 64'h40);
      step();
      chk("rd_mrv_t2",  64'(bus.mem_read_valid),      64'h1);
      step();
      chk("rd_crr_t3",  64'(bus.consumer_read_ready), 64'h0);
      bus.mem_read_ready[0] = 1'b1;
      bus.mem_read_data[0]  = 8'hA5;
      step();
      bus.mem_read_ready[0] = 1'b0;
      chk("rd_crr_t4",  64'(bus.consumer_read_ready),   64'h08);
      chk("rd_crd_t4",  64'(bus.consumer_read_data[3]), 64'hA5);
      chk("rd_mrv_t4",  64'(bus.mem_read_valid),        64'h0);
      bus.consumer_read_valid[3] = 1'b0;
      step();
      chk("rd_crr_t5",  64'(bus.consumer_read_ready),   64'h0);

      // write then read from consumer 1
      bus.consumer_write_valid[1]   = 1'b1;
      bus.consumer_write_address[1] = 8'h10;
      bus.consumer_write_data[1]    = 8'h7E;
      bus.consumer_read_valid[1]    = 1'b1;
      bus.consumer_read_address[1]  = 8'h20;
      step();
      chk("wr_mwv_t1",  64'(bus.mem_write_valid),      64'h1);
      chk("wr_mwa_t1",  64'(bus.mem_write_address[0]), 64'h10);
      chk("wr_mwd_t1",  64'(bus.mem_write_data[0]),    64'h7E);
      chk("wr_mrv_t1",  64'(bus.mem_read_valid),       64'h0);
      bus.mem_write_ready[0] = 1'b1;
      step();
      bus.mem_write_ready[0] = 1'b0;
      chk("wr_cwr_t2",  64'(bus.consumer_write_ready), 64'h02);
      chk("wr_mrv_t2",  64'(bus.mem_read_valid),       64'h0);
      bus.consumer_write_valid[1] = 1'b0;
      step();
      chk("wr_cwr_t3",  64'(bus.consumer_write_ready), 64'h0);
      chk("wr_mrv_t3",  64'(bus.mem_read_valid),       64'h0);
      step();
      chk("wr_mrv_t4",  64'(bus.mem_read_valid),       64'h1);
      chk("wr_mra_t4",  64'(bus.mem_read_address[0]),  64'h20);
      bus.mem_read_ready[0] = 1'b1;
      bus.mem_read_data[0]  = 8'h3C;
      step();
      bus.mem_read_ready[0] = 1'b0;
      chk("wr_crr_t5",  64'(bus.consumer_read_ready),   64'h02);
      chk("wr_crd_t5",  64'(bus.consumer_read_data[1]), 64'h3C);
      bus.consumer_read_valid[1] = 1'b0;
      step();
      chk("wr_crr_t6",  64'(bus.consumer_read_ready),   64'h0);

      // contention: consumers 0,2,5 on two channels
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.consumer_read_valid      = 8'b0010_0101;
      bus.consumer_read_address[0] = 8'h50;
      bus.consumer_read_address[2] = 8'h52;
      bus.consumer_read_address[5] = 8'h55;
      step();
      chk("ct_mrv_t1",  64'(bus.mem_read_valid),      64'h3);
      chk("ct_mra0_t1", 64'(bus.mem_read_address[0]), 64'h50);
      chk("ct_mra1_t1", 64'(bus.mem_read_address[1]), 64'h52);
      bus.mem_read_ready[1] = 1'b1;
      bus.mem_read_data[1]  = 8'h22;
      step();
      bus.mem_read_ready[1] = 1'b0;
      chk("ct_crr_t2",  64'(bus.consumer_read_ready),   64'h04);
      chk("ct_crd_t2",  64'(bus.consumer_read_data[2]), 64'h22);
      bus.consumer_read_valid[2] = 1'b0;
      step();
      chk("ct_crr_t3",  64'(bus.consumer_read_ready),   64'h0);
      chk("ct_mrv_t3",  64'(bus.mem_read_valid),        64'h1);
      step();
      chk("ct_mrv_t4",  64'(bus.mem_read_valid),        64'h3);
      chk("ct_mra1_t4", 64'(bus.mem_read_address[1]),   64'h55);
      bus.mem_read_ready   = 2'b11;
      bus.mem_read_data[0] = 8'h11;
      bus.mem_read_data[1] = 8'h5A;
      step();
      bus.mem_read_ready = 2'b00;
      chk("ct_crr_t5",  64'(bus.consumer_read_ready),   64'h21);
      chk("ct_crd0_t5", 64'(bus.consumer_read_data[0]), 64'h11);
      chk("ct_crd5_t5", 64'(bus.consumer_read_data[5]), 64'h5A);
      bus.consumer_read_valid = '0;
      step();
      chk("ct_crr_t6",  64'(bus.consumer_read_ready),   64'h0);

      // pointer after grants 0,2 then 5 sits at 6: consumer 7 outranks 1
      bus.consumer_read_valid      = 8'b1000_0010;
      bus.consumer_read_address[1] = 8'h61;
      bus.consumer_read_address[7] = 8'h67;
      step();
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      chk("pt_mra0", 64'(bus.mem_read_address[0]), 64'h67);
      chk("pt_mra1", 64'(bus.mem_read_address[1]), 64'h61);
`else
      chk("pt_mra0", 64'(bus.mem_read_address[0]), 64'h61);
      chk("pt_mra1", 64'(bus.mem_read_address[1]), 64'h67);
`endif
      bus.mem_read_ready   = 2'b11;
      bus.mem_read_data[0] = 8'hC0;
      bus.mem_read_data[1] = 8'hC1;
      step();
      bus.mem_read_ready = 2'b00;
      chk("pt_crr", 64'(bus.consumer_read_ready), 64'h82);
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      chk("pt_crd7", 64'(bus.consumer_read_data[7]), 64'hC0);
      chk("pt_crd1", 64'(bus.consumer_read_data[1]), 64'hC1);
`else
      chk("pt_crd1", 64'(bus.consumer_read_data[1]), 64'hC0);
      chk("pt_crd7", 64'(bus.consumer_read_data[7]), 64'hC1);
`endif
      bus.consumer_read_valid = '0;
      step();

      // fairness: all consumers requesting, memory answers in one cycle
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < NC; i++) begin
         cnt[i] = 0;
         bus.consumer_read_address[i] = 8'(8'h80 + i);
      end
      grants = 0;
      bus.consumer_read_valid = 8'hFF;
      for (int cyc = 0; cyc < 80 && grants < 16; cyc++) begin
         step();
         for (int c = 0; c < NCH; c++) begin
            bus.mem_read_ready[c] = bus.mem_read_valid[c];
            bus.mem_read_data[c]  = bus.mem_read_address[c] ^ 8'hFF;
            if (bus.mem_read_valid[c] && grants < 16) begin
               gi = int'(bus.mem_read_address[c]) - 128;
               if (gi >= 0 && gi < NC) cnt[gi]++;
               grants++;
            end
         end
         for (int i = 0; i < NC; i++) begin
            if (bus.consumer_read_ready[i]) begin
               e = 8'(8'h80 + i) ^ 8'hFF;
               chk("fr_crd", 64'(bus.consumer_read_data[i]), 64'(e));
               bus.consumer_read_valid[i] = 1'b0;
            end else if (!bus.consumer_read_valid[i]) begin
               bus.consumer_read_valid[i] = 1'b1;
            end
         end
      end
      chk("fr_grants", 64'(grants), 64'd16);
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      for (int i = 0; i < NC; i++) chk("fr_cnt", 64'(cnt[i]), 64'd2);
`else
      chk("fr_cnt0", 64'(cnt[0]), 64'd8);
      chk("fr_cnt1", 64'(cnt[1]), 64'd8);
      chk("fr_cnt7", 64'(cnt[7]), 64'd0);
`endif

      // reset while a read is waiting on memory
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.consumer_read_valid[6]   = 1'b1;
      bus.consumer_read_address[6] = 8'h66;
      step();
      chk("mr_mrv_pre", 64'(bus.mem_read_valid), 64'h1);
      reset = 1'b1;
      bus.consumer_read_valid[6] = 1'b0;
      step();
      chk_all_zero("mr");
      reset = 1'b0;
      bus.mem_read_ready[0] = 1'b1;
      bus.mem_read_data[0]  = 8'hAA;
      step();
      bus.mem_read_ready[0] = 1'b0;
      chk("mr_crr_p1", 64'(bus.consumer_read_ready), 64'h0);
      chk("mr_crd_p1", 64'(bus.consumer_read_data),  64'h0);
      step();
      chk("mr_crr_p2", 64'(bus.consumer_read_ready), 64'h0);

      // abandon: consumer 4 drops valid while its read is outstanding
      bus.consumer_read_valid[4]   = 1'b1;
      bus.consumer_read_address[4] = 8'h44;
      step();
      chk("ab_mrv_t1", 64'(bus.mem_read_valid),      64'h1);
      chk("ab_mra_t1", 64'(bus.mem_read_address[0]), 64'h44);
      bus.consumer_read_valid[4] = 1'b0;
      step();
      chk("ab_mrv_t2", 64'(bus.mem_read_valid),      64'h1);
      bus.mem_read_ready[0] = 1'b1;
      bus.mem_read_data[0]  = 8'h99;
      step();
      bus.mem_read_ready[0] = 1'b0;
      chk("ab_mrv_t3", 64'(bus.mem_read_valid),      64'h0);
      chk("ab_crr_t3", 64'(bus.consumer_read_ready), 64'h0);
      bus.consumer_read_valid[2]   = 1'b1;
      bus.consumer_read_address[2] = 8'h22;
      step();
      chk("ab_mrv_t4", 64'(bus.mem_read_valid),      64'h1);
      chk("ab_mra_t4", 64'(bus.mem_read_address[0]), 64'h22);
      bus.mem_read_ready[0] = 1'b1;
      bus.mem_read_data[0]  = 8'h77;
      step();
      bus.mem_read_ready[0] = 1'b0;
      chk("ab_crr_t5", 64'(bus.consumer_read_ready),   64'h04);
      chk("ab_crd_t5", 64'(bus.consumer_read_data[2]), 64'h77);
      bus.consumer_read_valid[2] = 1'b0;
      step();
      chk("ab_crr_t6", 64'(bus.consumer_read_ready),   64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
